// File: rtl/count_display.sv
// rtl/count_display.sv - binary to BCD converter with multiplexed three-digit seven-segment display
// Double-dabble runs one bit per clock; display scans the committed bcd value.
module count_display #(
  parameter int N     = 8,
  parameter int DWELL = 50000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         valid,
  input  logic [N-1:0] count,
  output logic         busy,
  output logic [11:0]  bcd,
  output logic [6:0]   seg,
  output logic [2:0]   an
);

  localparam int RW = $clog2(DWELL);

  typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;

  state_t       state, state_nx;
  logic [8:0]   sr;
  logic [11:0]  scratch;
  logic [3:0]   iter;
  logic [RW-1:0] refresh;
  logic [1:0]   sel;
  logic [3:0]   digit;
  logic         blank;

  // One double-dabble step: correct each digit, then shift in the next binary bit.
  function automatic logic [11:0] dabble_step(input logic [11:0] s, input logic b);
    logic [11:0] adj;
    for (int i = 0; i < 3; i++) begin
      adj[i*4 +: 4] = (s[i*4 +: 4] >= 4'd5) ? s[i*4 +: 4] + 4'd3 : s[i*4 +: 4];
    end
    return {adj[10:0], b};
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (valid) state_nx = CONV;
      CONV:    if (iter == 4'(N - 1)) state_nx = COMMIT;
      COMMIT:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // The captured value sits right-aligned, so bit N-1 is the next bit to feed in.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr      <= '0;
      scratch <= '0;
      iter    <= '0;
      bcd     <= '0;
    end else begin
      case (state)
        IDLE: if (valid) begin
          sr      <= 9'(count);
          scratch <= '0;
          iter    <= '0;
        end
        CONV: begin
          scratch <= dabble_step(scratch, sr[N-1]);
          sr      <= sr << 1;
          iter    <= iter + 4'd1;
        end
        COMMIT:  bcd <= scratch;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      refresh <= '0;
      sel     <= 2'd0;
    end else if (refresh == RW'(DWELL - 1)) begin
      refresh <= '0;
      sel     <= (sel == 2'd2) ? 2'd0 : sel + 2'd1;
    end else begin
      refresh <= refresh + RW'(1);
    end
  end

  always_comb begin
    digit = bcd[3:0];
    blank = 1'b0;
    an    = 3'b110;
    case (sel)
      2'd1: begin
        digit = bcd[7:4];
        blank = (bcd[11:8] == 4'd0) && (bcd[7:4] == 4'd0);
        an    = 3'b101;
      end
      2'd2: begin
        digit = bcd[11:8];
        blank = (bcd[11:8] == 4'd0);
        an    = 3'b011;
      end
      default: ;
    endcase
  end

  always_comb begin
    seg = 7'b1111111;
    if (!blank) begin
      case (digit)
        4'd0: seg = 7'b1000000;
        4'd1: seg = 7'b1111001;
        4'd2: seg = 7'b0100100;
        4'd3: seg = 7'b0110000;
        4'd4: seg = 7'b0011001;
        4'd5: seg = 7'b0010010;
        4'd6: seg = 7'b0000010;
        4'd7: seg = 7'b1111000;
        4'd8: seg = 7'b0000000;
        4'd9: seg = 7'b0010000;
        default: seg = 7'b1111111;
      endcase
    end
  end

endmodule

// File: doc/count_display.md
COUNT_DISPLAY -- requirements
Module: count_display

Interface
REQ-001 The block SHALL sit downstream of the letter-counter stage and accept its 8-bit match count C on input count.
REQ-002 Parameter: N, 8, width of count; legal range 1..9, so the maximum value 511 fits three decimal digits.
REQ-003 Parameter: DWELL, 50000, clk cycles each digit stays enabled; legal range >= 2.
REQ-004 Port: clk  input  1  single clock; all state updates on posedge clk.
REQ-005 Port: rst  input  1  reset, asynchronous and active-low (rst=0 resets).
REQ-006 Port: valid  input  1  single-cycle request to convert and display count.
REQ-007 Port: count  input  N  binary value to display, sampled only when a request is accepted.
REQ-008 Port: busy  output  1  high while a conversion is in progress.
REQ-009 Port: bcd  output  12  committed packed BCD {hundreds, tens, units}.
REQ-010 Port: seg  output  7  active-low segments {g,f,e,d,c,b,a}, bit0 = a.
REQ-011 Port: an  output  3  active-low one-hot digit enables; bit0 = units, bit1 = tens, bit2 = hundreds.

Function
REQ-012 Converter FSM states: IDLE, CONV, COMMIT; busy SHALL be 1 exactly when the state is not IDLE.
REQ-013 IDLE, valid=1 at edge k: capture count zero-extended to 9 bits into a shift register, clear the 12-bit scratch BCD and iteration counter, go to CONV.
REQ-014 IDLE, valid=0: hold all state.
REQ-015 Each CONV edge SHALL perform one double-dabble step: add 3 to every scratch digit >= 5, then shift {scratch, shift register} left one bit.
REQ-016 CONV SHALL perform exactly N steps, on edges k+1..k+N, then go to COMMIT.
REQ-017 COMMIT at edge k+N+1: bcd <= scratch, go to IDLE.
REQ-018 busy SHALL be high for exactly N+1 cycles per request; bcd SHALL change only at the COMMIT edge.
REQ-019 valid asserted while busy=1 SHALL be ignored and not queued.
REQ-020 valid asserted in the cycle after COMMIT (state IDLE) SHALL be accepted normally.
REQ-021 The refresh counter SHALL count 0..DWELL-1 and wrap to 0.
REQ-022 On each refresh wrap, digit select SHALL advance units -> tens -> hundreds -> units.
REQ-023 Refresh and digit select SHALL run independently of the converter state.
REQ-024 an SHALL be 110 for units, 101 for tens and 011 for hundreds.
REQ-025 seg SHALL be decoded combinationally from the selected digit of bcd, never from scratch.
REQ-026 Active-low decode, gfedcba: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-027 Leading-zero blanking (seg=1111111): hundreds blanked when it is 0; tens blanked when hundreds and tens are both 0; units never blanked.
REQ-028 A BCD digit above 9 (unreachable) SHALL decode to blank.

Reset
REQ-029 rst=0 SHALL asynchronously force: state IDLE, busy=0, bcd=12'h000, scratch, shift register and iteration counter to 0, refresh counter 0, digit select units.
REQ-030 Output after reset: an=110, seg=1000000.
REQ-031 Reset asserted mid-conversion SHALL abort it; no partial result reaches bcd.
REQ-032 After rst returns to 1, the first accepted valid SHALL behave as in REQ-013.

Verification
REQ-033 Release reset, hold valid=0 -> busy=0, bcd=000, an=110, seg=1000000.
REQ-034 count=173, valid pulse at edge k (N=8) -> busy=1 for 9 cycles; bcd=12'h173 after edge k+9.
REQ-035 Boundaries: count=255 -> bcd=12'h255; count=0 -> bcd=12'h000; N=9 with count=511 -> bcd=12'h511.
REQ-036 count=173 accepted, then valid with count=42 at edge k+3 -> request ignored, bcd=12'h173, busy falls after edge k+9.
REQ-037 count=7 with DWELL=4 -> an steps 110/101/011 every 4 cycles; seg is 1111000 on units and 1111111 on tens and hundreds.
REQ-038 Set bcd=12'h173, start a conversion of 99, drop rst at edge k+4 -> bcd=000, busy=0 immediately; a new request of 99 after release -> bcd=12'h099 with the hundreds digit blanked.
